serializer_reg: RTL and testbench
=================================

SERIALIZER_REG -- requirements
Module: serializer_reg

Interface
REQ-001 Parameter WIDTH, default 4: parallel word width; SHALL be >= 2.
REQ-002 Parameter MSB_FIRST, default 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
REQ-003 Parameter IDLE_LEVEL, default 0: ser_out level while not transmitting.
REQ-004 Clock and reset SHALL be: one clock, reset synchronous and active-high.
REQ-005 input_clock1_clk  in  1  sole clock, rising-edge.
REQ-006 input_push_button1_reset  in  1  synchronous active-high reset.
REQ-007 shift_tick  in  1  bit-advance enable; one bit per cycle with tick high.
REQ-008 in_valid  in  1  parallel word offered.
REQ-009 in_data  in  WIDTH  parallel word.
REQ-010 in_ready  out  1  word accepted on a cycle with in_valid & in_ready.
REQ-011 ser_out  out  1  serial data.
REQ-012 ser_valid  out  1  ser_out carries a frame bit.
REQ-013 frame_start  out  1  high while the first bit of a frame is driven.
REQ-014 load_shift  out  1  1 in IDLE (load mode), 0 while shifting.
REQ-015 shreg_q  out  WIDTH  current shift-register contents.
REQ-016 done  out  1  one-cycle pulse after the last bit of a frame when no new word follows.

Function
REQ-017 FSM states SHALL be IDLE, SHIFT, PARITY (PARITY only with the macro in REQ-031).
REQ-018 in_ready SHALL be 1 in IDLE; 1 in the final-bit cycle when shift_tick=1 (back-to-back); otherwise 0.
REQ-019 An accept at edge t SHALL load shreg at t, giving state SHIFT, bit counter 0, ser_valid=1, frame_start=1 and ser_out = first bit from t+1.
REQ-020 In SHIFT with shift_tick=0, all state and outputs SHALL hold.
REQ-021 In SHIFT with shift_tick=1 and counter < WIDTH-1: shreg shifts one position toward the output end, zero-filling the vacated end; counter increments; frame_start clears.
REQ-022 On tick in the final bit (counter = WIDTH-1): go to PARITY if enabled; else load a new word if one is accepted the same cycle; else go to IDLE and pulse done for one cycle.
REQ-023 In IDLE, ser_out SHALL equal IDLE_LEVEL and ser_valid=0; shreg_q SHALL hold its last value.
REQ-024 The counter SHALL be $clog2(WIDTH) bits wide and SHALL never exceed WIDTH-1; it does not wrap.
REQ-025 in_valid without in_ready SHALL have no effect; in_data SHALL be sampled only on accept.
REQ-026 Latency from accept to first bit SHALL be exactly 1 cycle; a frame SHALL occupy WIDTH ticks, or WIDTH+1 with parity.

Reset
REQ-027 Reset SHALL dominate all inputs, including mid-frame; the in-flight word SHALL be discarded.
REQ-028 After reset: state IDLE, shreg_q=0, counter=0, ser_out=IDLE_LEVEL, ser_valid=0, frame_start=0, done=0, load_shift=1, in_ready=1.
REQ-029 In the cycle reset is asserted, in_ready SHALL NOT cause an accept.

Configuration
REQ-030 Macro SERIALIZER_PARITY_EN SHALL control the parity feature.
REQ-031 With the macro defined: after the final data bit, one PARITY bit equal to the even parity (XOR) of the accepted word, held until a tick. The PARITY tick SHALL either load a new word (in_ready=1 in that cycle) or go to IDLE and pulse done.
REQ-032 Without the macro: no PARITY state and no parity logic.

Structure
REQ-033 Package serializer_pkg SHALL hold the state enum (IDLE, SHIFT, PARITY) and the state encoding width.
REQ-034 Sub-module serializer_bit_counter (WIDTH-parametrised counter with clear, enable and last-flag) SHALL provide the bit count.

Verification
REQ-035 WIDTH=4, MSB_FIRST=1, tick every cycle, accept 4'b1011 -> ser_out 1,0,1,1 with frame_start on the first bit only; then done=1 for one cycle and in_ready=1.
REQ-036 MSB_FIRST=0, accept 4'b1011, tick every 3rd cycle -> ser_out 1,1,0,1, each bit held 3 cycles; shreg_q shifts toward bit 0 with zero fill.
REQ-037 in_valid held high with words 4'hA then 4'h5 -> second accept in the final-bit tick cycle; 8 continuous bits 1010_0101; no done between frames; done once after the end.
REQ-038 Reset asserted at bit 2 of 4'hF -> next cycle: IDLE, shreg_q=0, ser_out=IDLE_LEVEL, ser_valid=0, no done pulse.
REQ-039 SERIALIZER_PARITY_EN defined, accept 4'b0111 -> 5 bits 0,1,1,1,1 (parity 1); accept 4'b0011 -> parity bit 0.
REQ-040 in_valid pulsed mid-frame with in_ready=0 -> word ignored; the current frame completes unchanged.

Source files
------------

// File: rtl/serializer_pkg.sv
// Shared types for the parallel-to-serial shifter: FSM state enum and its encoding width.
// Imported by serializer_reg and serializer_bit_counter.
package serializer_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  // Width of a counter able to index every bit of a WIDTH-bit word.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serializer_bit_counter.sv
// Bit-position counter for the serializer: clear dominates enable, saturates at WIDTH-1.
// Registered count, combinational last flag; no handshake of its own.
module serializer_bit_counter
  import serializer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt_q,
  output logic          last
);

  logic [CW-1:0] cnt_d;

  assign last = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !last) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serializer_reg.sv
// Parallel-to-serial shifter: accepts a WIDTH-bit word, first bit appears 1 cycle after accept,
// one bit per shift_tick; in_ready only in IDLE or on the closing tick. Optional parity bit: SERIALIZER_PARITY_EN.
module serializer_reg
  import serializer_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int MSB_FIRST  = 1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             input_clock1_clk,
  input  logic             input_push_button1_reset,
  input  logic             shift_tick,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             load_shift,
  output logic [WIDTH-1:0] shreg_q,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_d;
  logic [WIDTH-1:0] shreg_next;
  logic             head_bit;
  logic             done_q, done_d;
  logic             accept;
  logic             cnt_clr, cnt_en, cnt_last;
  logic [CW-1:0]    cnt_q;
`ifdef SERIALIZER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // The output end of the register is fixed by MSB_FIRST; the far end zero-fills.
  assign head_bit   = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
  assign shreg_next = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0}
                                       : {1'b0, shreg_q[WIDTH-1:1]};
  assign done = done_q;

  serializer_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_counter (
    .clk   (input_clock1_clk),
    .rst   (input_push_button1_reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt_q (cnt_q),
    .last  (cnt_last)
  );

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    done_d      = 1'b0;
    in_ready    = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    ser_valid   = 1'b0;
    ser_out     = IDLE_LEVEL;
    frame_start = 1'b0;
    load_shift  = 1'b0;
    accept      = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    parity_d    = parity_q;
`endif

    case (state_q)
      IDLE: begin
        in_ready   = 1'b1;
        load_shift = 1'b1;
      end
      SHIFT: begin
        ser_valid   = 1'b1;
        ser_out     = head_bit;
        frame_start = (cnt_q == '0);
        if (shift_tick) begin
          if (!cnt_last) begin
            shreg_d = shreg_next;
            cnt_en  = 1'b1;
          end else begin
`ifdef SERIALIZER_PARITY_EN
            state_d = PARITY;
`else
            // Closing tick: shreg keeps its final value; a new word may chain in.
            in_ready = 1'b1;
            state_d  = IDLE;
            cnt_clr  = 1'b1;
            done_d   = 1'b1;
`endif
          end
        end
      end
`ifdef SERIALIZER_PARITY_EN
      PARITY: begin
        ser_valid = 1'b1;
        ser_out   = parity_q;
        if (shift_tick) begin
          in_ready = 1'b1;
          state_d  = IDLE;
          cnt_clr  = 1'b1;
          done_d   = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    // Reset blocks the accept even though in_ready may read high that cycle.
    accept = in_valid & in_ready & ~input_push_button1_reset;
    if (accept) begin
      shreg_d = in_data;
      state_d = SHIFT;
      cnt_clr = 1'b1;
      done_d  = 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_d = ^in_data;
`endif
    end
  end

  always_ff @(posedge input_clock1_clk) begin
    if (input_push_button1_reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      done_q   <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      done_q   <= done_d;
`ifdef SERIALIZER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_serializer_reg.sv
// Bench for serializer_reg: an MSB-first and an LSB-first instance share stimulus; a frame-level
// model (remaining bits, bits sent, word) is checked every cycle, plus literal frame captures.
module tb_serializer_reg;

  localparam int W = 4;
`ifdef SERIALIZER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FB = W + (PAR ? 1 : 0);

  logic         clk = 1'b0;
  logic         rst, tick, vld;
  logic [W-1:0] data;

  logic         o_rdy [2];
  logic         o_so  [2];
  logic         o_sv  [2];
  logic         o_fs  [2];
  logic         o_ls  [2];
  logic         o_dn  [2];
  logic [W-1:0] o_sh  [2];

  int tests_run = 0;
  int fails     = 0;
  bit chk_en    = 1'b0;

  always #5 clk = ~clk;

  serializer_reg #(.WIDTH(W), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) dut_msb (
    .input_clock1_clk        (clk),
    .input_push_button1_reset(rst),
    .shift_tick              (tick),
    .in_valid                (vld),
    .in_data                 (data),
    .in_ready                (o_rdy[0]),
    .ser_out                 (o_so[0]),
    .ser_valid               (o_sv[0]),
    .frame_start             (o_fs[0]),
    .load_shift              (o_ls[0]),
    .shreg_q                 (o_sh[0]),
    .done                    (o_dn[0])
  );

  serializer_reg #(.WIDTH(W), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) dut_lsb (
    .input_clock1_clk        (clk),
    .input_push_button1_reset(rst),
    .shift_tick              (tick),
    .in_valid                (vld),
    .in_data                 (data),
    .in_ready                (o_rdy[1]),
    .ser_out                 (o_so[1]),
    .ser_valid               (o_sv[1]),
    .frame_start             (o_fs[1]),
    .load_shift              (o_ls[1]),
    .shreg_q                 (o_sh[1]),
    .done                    (o_dn[1])
  );

  // Frame model: bits still to send, bits already sent, the accepted word, its parity.
  int           m_left [2] = '{0, 0};
  int           m_k    [2] = '{0, 0};
  logic [W-1:0] m_word [2] = '{'0, '0};
  logic         m_par  [2] = '{1'b0, 1'b0};
  logic         m_done [2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit rdy, acc;
      rdy = (m_left[d] == 0) || (tick && m_left[d] == 1);
      if (rst) begin
        m_left[d] = 0;
        m_k[d]    = 0;
        m_word[d] = '0;
        m_par[d]  = 1'b0;
        m_done[d] = 1'b0;
      end else begin
        acc       = vld && rdy;
        m_done[d] = 1'b0;
        if (m_left[d] > 0 && tick) begin
          m_left[d] = m_left[d] - 1;
          m_k[d]    = m_k[d] + 1;
          if (m_left[d] == 0 && !acc) m_done[d] = 1'b1;
        end
        if (acc) begin
          m_word[d] = data;
          m_k[d]    = 0;
          m_left[d] = FB;
          m_par[d]  = ^data;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        logic [W+5:0] act, exp;
        logic [W-1:0] e_sh;
        logic         e_vld, e_bit;
        int           s;
        e_vld = (m_left[d] > 0);
        s     = (m_k[d] < W - 1) ? m_k[d] : W - 1;
        e_sh  = (d == 0) ? (m_word[d] << s) : (m_word[d] >> s);
        if (m_k[d] >= W)  e_bit = m_par[d];
        else if (d == 0)  e_bit = m_word[d][W-1-m_k[d]];
        else              e_bit = m_word[d][m_k[d]];
        exp = {(m_left[d] == 0) || (tick && m_left[d] == 1),
               e_vld ? e_bit : 1'b0, e_vld, e_vld && m_k[d] == 0,
               !e_vld, m_done[d], e_sh};
        act = {o_rdy[d], o_so[d], o_sv[d], o_fs[d], o_ls[d], o_dn[d], o_sh[d]};
        tests_run++;
        if (act !== exp) begin
          fails++;
          $display("FAIL model_cmp dut%0d t=%0t {rdy,out,vld,fs,ls,done,shreg} got %b expected %b",
                   d, $time, act, exp);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int ncyc, output logic [9:0] c0, output logic [9:0] c1,
                         output int nb, output int nd, output int nfs);
    c0 = '0; c1 = '0; nb = 0; nd = 0; nfs = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (o_sv[0] && tick) begin c0 = {c0[8:0], o_so[0]}; nb++; end
      if (o_sv[1] && tick) c1 = {c1[8:0], o_so[1]};
      if (o_fs[0]) nfs++;
      if (o_dn[0]) nd++;
      step();
    end
  endtask

  task automatic send(input logic [W-1:0] w, output logic [9:0] c0, output logic [9:0] c1,
                      output int nb, output int nd, output int nfs);
    vld = 1'b1; data = w; tick = 1'b1;
    step();
    vld = 1'b0; data = W'($urandom);
    capture(FB + 2, c0, c1, nb, nd, nfs);
  endtask

  initial begin
    logic [9:0] c0, c1;
    int nb, nd, nfs, acc_n, nvalid;
    logic [W-1:0] sh_mid;

    rst = 1'b1; tick = 1'b0; vld = 1'b0; data = '0;
    step();
    chk_en = 1'b1;
    step();
    chk("reset_in_ready", 32'(o_rdy[0]), 1);
    chk("reset_load_shift", 32'(o_ls[0]), 1);
    chk("reset_idle_outputs", {o_sv[0], o_so[0], o_fs[0], o_dn[0], o_sh[0]}, 0);
    rst = 1'b0;
    step();

    // Basic frame, tick every cycle.
    send(4'b1011, c0, c1, nb, nd, nfs);
    chk("t1_msb_bits", 32'(c0), PAR ? 32'b10111 : 32'b1011);
    chk("t1_lsb_bits", 32'(c1), PAR ? 32'b11011 : 32'b1101);
    chk("t1_bit_count", nb, FB);
    chk("t1_frame_start_cycles", nfs, 1);
    chk("t1_done_pulses", nd, 1);
    chk("t1_ready_after", 32'(o_rdy[0]), 1);

    // Tick every third cycle on the LSB-first instance.
    vld = 1'b1; data = 4'b1011; tick = 1'b0;
    step();
    vld = 1'b0;
    c1 = '0; nvalid = 0; sh_mid = '0;
    for (int c = 0; c < 3 * FB + 3; c++) begin
      tick = (c % 3 == 2);
      @(negedge clk);
      if (o_sv[1]) nvalid++;
      if (o_sv[1] && tick) c1 = {c1[8:0], o_so[1]};
      if (c == 3) sh_mid = o_sh[1];
      step();
    end
    tick = 1'b0;
    chk("t2_lsb_bits", 32'(c1), PAR ? 32'b11011 : 32'b1101);
    chk("t2_valid_cycles", nvalid, 3 * FB);
    chk("t2_shreg_after_one_shift", 32'(sh_mid), 32'b0101);

    // Back-to-back words with in_valid held high.
    vld = 1'b1; data = 4'hA; tick = 1'b1;
    acc_n = 0; c0 = '0; nb = 0; nd = 0;
    for (int c = 0; c < 2 * FB + 4; c++) begin
      @(negedge clk);
      if (vld && o_rdy[0]) acc_n++;
      if (o_sv[0]) begin c0 = {c0[8:0], o_so[0]}; nb++; end
      if (o_dn[0]) nd++;
      step();
      if (acc_n == 1) data = 4'h5;
      if (acc_n >= 2) vld = 1'b0;
    end
    chk("t3_bits", 32'(c0), PAR ? 32'b1010001010 : 32'b10100101);
    chk("t3_bit_count", nb, 2 * FB);
    chk("t3_accepts", acc_n, 2);
    chk("t3_done_pulses", nd, 1);

    // Reset at bit 2 of 4'hF, with a word offered during the reset cycle.
    vld = 1'b1; data = 4'hF; tick = 1'b1;
    step();
    vld = 1'b0;
    step();
    step();
    rst = 1'b1; vld = 1'b1; data = 4'h3;
    step();
    rst = 1'b0; vld = 1'b0;
    chk("t4_after_reset", {o_sv[0], o_so[0], o_sh[0]}, 0);
    chk("t4_load_shift", 32'(o_ls[0]), 1);
    nd = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (o_dn[0] || o_sv[0]) nd++;
      step();
    end
    chk("t4_no_done_no_frame", nd, 0);

    // Word offered mid-frame while in_ready is low must be ignored.
    vld = 1'b1; data = 4'b1100; tick = 1'b0;
    step();
    vld = 1'b0;
    step();
    vld = 1'b1; data = 4'b0011;
    step();
    vld = 1'b0; tick = 1'b1;
    capture(FB + 2, c0, c1, nb, nd, nfs);
    chk("t5_frame_unchanged", 32'(c0), PAR ? 32'b11000 : 32'b1100);
    chk("t5_done_pulses", nd, 1);

    // Parity-sensitive words.
    send(4'b0111, c0, c1, nb, nd, nfs);
    chk("t6_word_0111", 32'(c0), PAR ? 32'b01111 : 32'b0111);
    send(4'b0011, c0, c1, nb, nd, nfs);
    chk("t6_word_0011", 32'(c0), PAR ? 32'b00110 : 32'b0011);

    tick = 1'b0;
    step();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
